// File: rtl/pump_control_top.sv
// Purpose : two-pump drain controller; level electrodes -> sync -> stability filter -> hysteresis FSM -> pump enables.
// Latency : 4 + STABLE_CYCLES rising edges from a held change on X to Y/FAULT.
// Backpressure: none; free-running level sampler, outputs decoded from registered state only.
//
// Ports:
//   CLK   in   1  system clock, rising edge
//   RST   in   1  synchronous active-high reset
//   X     in   3  level electrodes (thermometer code, X[0] low .. X[2] high), 1 = wetted
//   Y     out  2  pump enables, Y[0] pump A, Y[1] pump B
//   FAULT out  1  high while an implausible level code is held
// Optional macro: PUMP_ALTERNATE_EN -- alternate the single running pump on each IDLE->ONE entry.
module pump_control_top #(
    parameter int unsigned STABLE_CYCLES = 1   // legal range 1..255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] X,
    output logic [1:0] Y,
    output logic       FAULT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2,
        FLT  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_cand;
    logic [2:0] r_level;
    logic [7:0] r_cnt;
    state_t     r_state;
    state_t     w_next;
    logic       w_level_ok;

    // Two-flop synchroniser: electrodes are asynchronous board inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= 3'b000;
            r_s2 <= 3'b000;
        end else begin
            r_s1 <= X;
            r_s2 <= r_s1;
        end
    end

    // Stability filter: a code must sit unchanged in r_s2 for STABLE_CYCLES
    // further samples after becoming the candidate before it is accepted.
    // Any change of r_s2 restarts the count with the new candidate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cand  <= 3'b000;
            r_level <= 3'b000;
            r_cnt   <= 8'd0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= 8'd0;
        end else if (r_cand != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_cand;
                r_cnt   <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign w_level_ok = (r_level == 3'b000) || (r_level == 3'b001) ||
                        (r_level == 3'b011) || (r_level == 3'b111);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hysteresis: mid level starts one pump only from IDLE/FLT and keeps TWO
    // running; low level keeps ONE running but never starts a pump.
    always_comb begin
        w_next = r_state;
        if (!w_level_ok) begin
            w_next = FLT;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_level == 3'b111)      w_next = TWO;
                    else if (r_level == 3'b011) w_next = ONE;
                    else                        w_next = IDLE;
                end
                ONE: begin
                    if (r_level == 3'b111)      w_next = TWO;
                    else if (r_level == 3'b000) w_next = IDLE;
                    else                        w_next = ONE;
                end
                TWO: begin
                    if (r_level == 3'b001)      w_next = ONE;
                    else if (r_level == 3'b000) w_next = IDLE;
                    else                        w_next = TWO;
                end
                FLT: begin
                    if (r_level == 3'b111)      w_next = TWO;
                    else if (r_level == 3'b011) w_next = ONE;
                    else                        w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef PUMP_ALTERNATE_EN
    logic r_lead;

    // Only a fresh start from IDLE swaps the lead pump; falling back from
    // TWO or recovering from FLT keeps the current lead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lead <= 1'b0;
        end else if ((r_state == IDLE) && (w_next == ONE)) begin
            r_lead <= ~r_lead;
        end
    end
`endif

    // Outputs decode only from the state register, so they cannot glitch.
    always_comb begin
        Y     = 2'b00;
        FAULT = 1'b0;
        unique case (r_state)
            IDLE: Y = 2'b00;
`ifdef PUMP_ALTERNATE_EN
            ONE:  Y = r_lead ? 2'b10 : 2'b01;
`else
            ONE:  Y = 2'b01;
`endif
            TWO:  Y = 2'b11;
            FLT:  FAULT = 1'b1;
            default: Y = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_pump_control_top.sv
// Purpose : directed bench for pump_control_top, default and STABLE_CYCLES=4 instances sharing stimulus.
// Latency : checks outputs on every falling edge against a history-window model.
// Backpressure: n/a.
module tb_pump_control_top;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] X;
    logic [1:0] y1;
    logic [1:0] y4;
    logic       f1;
    logic       f4;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

`ifdef PUMP_ALTERNATE_EN
    localparam logic [1:0] ONE_PRE   = 2'b10;
    localparam logic [1:0] ONE_FIRST = 2'b10;
`else
    localparam logic [1:0] ONE_PRE   = 2'b01;
    localparam logic [1:0] ONE_FIRST = 2'b01;
`endif

    always #5 CLK = ~CLK;

    pump_control_top dut1 (
        .CLK   (CLK),
        .RST   (RST),
        .X     (X),
        .Y     (y1),
        .FAULT (f1)
    );

    pump_control_top #(.STABLE_CYCLES(4)) dut4 (
        .CLK   (CLK),
        .RST   (RST),
        .X     (X),
        .Y     (y4),
        .FAULT (f4)
    );

    // Model: the accepted level is the newest sample whose window of N+1
    // consecutive synchronised samples (two edges old) is uniform; pump demand
    // follows a table of wetted-electrode count with hysteresis.
    logic [2:0] hist [2][260];
    logic [2:0] mlvl [2];
    int         mpumps [2];
    bit         mfault [2];
    bit         mlead  [2];
    int         nwin   [2];

    function automatic logic [2:0] model_out(int d);
        logic [2:0] r;
        if (mfault[d])           r = 3'b100;
        else if (mpumps[d] == 2) r = 3'b011;
        else if (mpumps[d] == 1) r = mlead[d] ? 3'b010 : 3'b001;
        else                     r = 3'b000;
        return r;
    endfunction

    initial begin
        nwin[0] = 1;
        nwin[1] = 4;
        forever begin
            @(posedge CLK);
            for (int d = 0; d < 2; d++) begin
                if (RST) begin
                    for (int k = 0; k < 260; k++) hist[d][k] = 3'b000;
                    mlvl[d]   = 3'b000;
                    mpumps[d] = 0;
                    mfault[d] = 1'b0;
                    mlead[d]  = 1'b0;
                end else begin
                    int  wet;
                    int  p;
                    bit  same;
                    wet = int'(mlvl[d][0]) + int'(mlvl[d][1]) + int'(mlvl[d][2]);
                    if (!(mlvl[d] inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
                        mpumps[d] = 0;
                        mfault[d] = 1'b1;
                    end else begin
                        if (wet == 3)      p = 2;
                        else if (wet == 2) p = (mpumps[d] == 2) ? 2 : 1;
                        else if (wet == 1) p = (mpumps[d] == 0) ? 0 : 1;
                        else               p = 0;
`ifdef PUMP_ALTERNATE_EN
                        if (mpumps[d] == 0 && !mfault[d] && p == 1) mlead[d] = ~mlead[d];
`endif
                        mpumps[d] = p;
                        mfault[d] = 1'b0;
                    end
                    for (int k = 259; k > 0; k--) hist[d][k] = hist[d][k-1];
                    hist[d][0] = X;
                    same = 1'b1;
                    for (int k = 3; k <= nwin[d] + 2; k++)
                        if (hist[d][k] != hist[d][2]) same = 1'b0;
                    if (same) mlvl[d] = hist[d][2];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got={FAULT,Y}=%b want=%b at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("cyc_n1", {f1, y1}, model_out(0));
                check("cyc_n4", {f4, y4}, model_out(1));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Literal expectation pinned against both the DUT and the model.
    task automatic lit1(input string nm, input logic [2:0] exp);
        check({nm, "_dut"}, {f1, y1}, exp);
        check({nm, "_mdl"}, model_out(0), exp);
    endtask

    task automatic lit4(input string nm, input logic [2:0] exp);
        check({nm, "_dut"}, {f4, y4}, exp);
        check({nm, "_mdl"}, model_out(1), exp);
    endtask

    task automatic do_reset;
        RST = 1'b1;
        X   = 3'b000;
        cyc(2);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        X   = 3'b111;
        cyc(1);
        chk_en = 1'b1;
        lit1("rst_a", 3'b000);
        cyc(1);
        lit1("rst_b", 3'b000);
        RST = 1'b0;
        cyc(4);
        lit1("rel_e4", 3'b000);
        cyc(1);
        lit1("rel_e5", 3'b011);
        cyc(2);
        lit4("rel4_e7", 3'b000);
        cyc(1);
        lit4("rel4_e8", 3'b011);

        // Rising ramp, two cycles per step.
        do_reset();
        X = 3'b000; cyc(2);
        X = 3'b001; cyc(2);
        lit1("ramp_001", 3'b000);
        X = 3'b011; cyc(2);
        X = 3'b111; cyc(2);
        lit1("ramp_011_e4", 3'b000);
        cyc(1);
        lit1("ramp_011_e5", {1'b0, ONE_PRE});
        cyc(2);
        lit1("ramp_111_e5", 3'b011);
        cyc(4);

        // Falling ramp: hysteresis keeps TWO at mid level.
        X = 3'b011; cyc(6);
        lit1("fall_011", 3'b011);
        X = 3'b001; cyc(6);
        lit1("fall_001", {1'b0, ONE_PRE});
        X = 3'b000; cyc(6);
        lit1("fall_000", 3'b000);

        // Implausible codes.
        X = 3'b111; cyc(6);
        lit1("pre_inv", 3'b011);
        X = 3'b101; cyc(6);
        lit1("inv_101", 3'b100);
        X = 3'b011; cyc(4);
        lit1("inv_hold", 3'b100);
        cyc(2);
        lit1("inv_exit", {1'b0, ONE_PRE});
        X = 3'b010; cyc(6);
        lit1("inv_010", 3'b100);
        X = 3'b110; cyc(6);
        lit1("inv_110", 3'b100);
        X = 3'b000; cyc(6);
        lit1("inv_to_idle", 3'b000);

        // Glitch shorter than the 4-cycle window is ignored.
        do_reset();
        X = 3'b000; cyc(6);
        X = 3'b111; cyc(2);
        X = 3'b000; cyc(10);
        lit4("glitch", 3'b000);
        lit1("glitch_n1_back", 3'b000);
        X = 3'b111; cyc(7);
        lit4("hold_e7", 3'b000);
        cyc(1);
        lit4("hold_e8", 3'b011);

        // Two consecutive IDLE->ONE->IDLE cycles.
        do_reset();
        X = 3'b011; cyc(6);
        lit1("alt_first", {1'b0, ONE_FIRST});
        X = 3'b000; cyc(6);
        lit1("alt_idle", 3'b000);
        X = 3'b011; cyc(6);
        lit1("alt_second", 3'b001);

        // Reset while pumping.
        X = 3'b111; cyc(6);
        lit1("mid_run", 3'b011);
        RST = 1'b1; cyc(1);
        lit1("mid_rst", 3'b000);
        lit4("mid_rst4", 3'b000);
        RST = 1'b0; X = 3'b000; cyc(2);
        lit1("post_rst", 3'b000);
        cyc(8);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
